// File: rtl/reg_file_mp_sb.sv
// reg_file_mp_sb: multi-port register file with same-cycle write bypass and pending-write scoreboard
module reg_file_mp_sb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 15,
  parameter int NUM_RD      = 3,
  parameter int RESET_INDEX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      pending_vec
);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0] pending, w0, w1, iss;
  logic [2**ADDR_W-1:0][DATA_W-1:0] rv;
  logic [2**ADDR_W-1:0] pv;
  // one-hot decode of write and issue destinations; out-of-range addresses decode to nothing
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w0[i]  = wr0_en && wr0_addr == ADDR_W'(i);
      w1[i]  = wr1_en && wr1_addr == ADDR_W'(i);
      iss[i] = issue_en && issue_addr == ADDR_W'(i);
    end
  end
  // zero-extended images so unimplemented addresses read as 0 / not pending
  always_comb begin
    rv = '0;
    pv = '0;
    rv[NUM_REGS-1:0] = regs;
    pv[NUM_REGS-1:0] = pending;
  end
  // commit writes (wr1 beats wr0) and update scoreboard (flush > issue set > write clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]    <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
        pending[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]    <= w1[i] ? wr1_data : w0[i] ? wr0_data : regs[i];
        pending[i] <= !flush && (iss[i] || (pending[i] && !w0[i] && !w1[i]));
      end
    end
  end
  assign pending_vec = pending;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic in_r, b0, b1;
    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign in_r = {1'b0, a} < NR;
    assign b1   = wr1_en && wr1_addr == a;
    assign b0   = wr0_en && wr0_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = !in_r ? '0 : b1 ? wr1_data : b0 ? wr0_data : rv[a];
    assign rd_pending[k] = in_r && !b0 && !b1 && pv[a];
  end
endmodule

// File: tb/tb_reg_file_mp_sb.sv
// tb_reg_file_mp_sb: directed vectors checked against a per-cycle spec model plus literal expectations
module tb_reg_file_mp_sb;
  logic clk = 0, rst = 1;
  logic [11:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic [2:0]  rd_pending;
  logic wr0_en = 0, wr1_en = 0, issue_en = 0, flush = 0;
  logic [3:0] wr0_addr = '0, wr1_addr = '0, issue_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic [14:0] pending_vec;
  int total = 0, bad = 0;
  logic [31:0] mreg [15];
  logic [14:0] mpend;

  reg_file_mp_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .pending_vec(pending_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // spec model: reset image, write commit (wr1 last so it wins), then scoreboard priority
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) mreg[i] = 32'(i);
      mpend = '0;
    end else begin
      if (wr0_en && wr0_addr < 15) begin mreg[wr0_addr] = wr0_data; mpend[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr < 15) begin mreg[wr1_addr] = wr1_data; mpend[wr1_addr] = 1'b0; end
      if (flush) mpend = '0;
      else if (issue_en && issue_addr < 15) mpend[issue_addr] = 1'b1;
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int a;
      logic [31:0] ed;
      logic ep;
      a = int'(rd_addr[k*4 +: 4]);
      if (a >= 15) begin ed = 0; ep = 0; end
      else if (wr1_en && int'(wr1_addr) == a) begin ed = wr1_data; ep = 0; end
      else if (wr0_en && int'(wr0_addr) == a) begin ed = wr0_data; ep = 0; end
      else begin ed = mreg[a]; ep = mpend[a]; end
      chk($sformatf("model rd_data[%0d]", k), rd_data[k*32 +: 32], ed);
      chk($sformatf("model rd_pending[%0d]", k), 32'(rd_pending[k]), 32'(ep));
    end
    chk("model pending_vec", 32'(pending_vec), 32'(mpend));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0; flush = 0;
  endtask

  initial begin
    cyc(); cyc();
    rst = 0;
    cyc();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAA; issue_en = 1; issue_addr = 14;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'h1234;
    cyc(); idle();
    rd_addr = {4'd14, 4'd7, 4'd0};
    #1;
    chk("pre-reset r7", rd_data[63:32], 32'hAA);
    chk("pre-reset pend14", 32'(pending_vec[14]), 32'd1);
    rst = 1;
    #1;
    chk("reset r0", rd_data[31:0], 32'd0);
    chk("reset r7", rd_data[63:32], 32'd7);
    chk("reset r14", rd_data[95:64], 32'd14);
    chk("reset pending_vec", 32'(pending_vec), 32'd0);
    chk("reset rd_pending", 32'(rd_pending), 32'd0);
    cyc();
    rst = 0;
    cyc();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    cyc(); idle();
    rd_addr = {4'd0, 4'd0, 4'd5};
    #1 chk("write r5", rd_data[31:0], 32'hDEADBEEF);
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11; wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
    rd_addr = {4'd5, 4'd3, 4'd3};
    #1 chk("bypass wr1 wins", rd_data[31:0], 32'h22);
    cyc(); idle();
    #1 chk("r3 after edge", rd_data[63:32], 32'h22);
    wr0_en = 1; wr0_addr = 8; wr0_data = 32'h80;
    rd_addr = {4'd8, 4'd3, 4'd5};
    #1 chk("bypass wr0", rd_data[95:64], 32'h80);
    cyc(); idle();
    issue_en = 1; issue_addr = 4;
    cyc(); idle();
    rd_addr = {4'd0, 4'd0, 4'd4};
    #1;
    chk("issue pend4", 32'(pending_vec[4]), 32'd1);
    chk("issue rd_pending", 32'(rd_pending[0]), 32'd1);
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'd9;
    #1;
    chk("bypass clears rd_pending", 32'(rd_pending[0]), 32'd0);
    chk("bypass data 9", rd_data[31:0], 32'd9);
    chk("pend4 still set", 32'(pending_vec[4]), 32'd1);
    cyc(); idle();
    #1 chk("write clears pend4", 32'(pending_vec[4]), 32'd0);
    issue_en = 1; issue_addr = 6; wr0_en = 1; wr0_addr = 6; wr0_data = 32'h66;
    cyc(); idle();
    rd_addr = {4'd0, 4'd0, 4'd6};
    #1;
    chk("issue beats clear", 32'(pending_vec[6]), 32'd1);
    chk("r6 updated", rd_data[31:0], 32'h66);
    issue_en = 1; issue_addr = 6;
    cyc(); idle();
    wr1_en = 1; wr1_addr = 6; wr1_data = 32'h67;
    cyc(); idle();
    #1 chk("single write clears double issue", 32'(pending_vec[6]), 32'd0);
    issue_en = 1; issue_addr = 9;
    cyc(); idle();
    flush = 1; issue_en = 1; issue_addr = 2; wr0_en = 1; wr0_addr = 2; wr0_data = 32'h55;
    cyc(); idle();
    rd_addr = {4'd0, 4'd0, 4'd2};
    #1;
    chk("flush pending_vec", 32'(pending_vec), 32'd0);
    chk("flush r2", rd_data[31:0], 32'h55);
    wr0_en = 1; wr0_addr = 15; wr0_data = 32'hFFFF_FFFF; issue_en = 1; issue_addr = 15;
    wr1_en = 1; wr1_addr = 15; wr1_data = 32'hCAFE;
    rd_addr = {4'd14, 4'd15, 4'd0};
    #1;
    chk("oor read data", rd_data[63:32], 32'd0);
    chk("oor read pend", 32'(rd_pending[1]), 32'd0);
    cyc(); idle();
    #1 chk("oor pending_vec", 32'(pending_vec), 32'd0);
    for (int i = 0; i < 16; i += 3) begin
      rd_addr = {4'(i + 2), 4'(i + 1), 4'(i)};
      cyc();
    end
    rd_addr = {4'd14, 4'd1, 4'd0};
    #1;
    chk("final r0", rd_data[31:0], 32'h1234 & 32'h0);
    chk("final r14", rd_data[95:64], 32'd14);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
